// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared state type and width defaults for the memory stage.
package mem_access_pkg;
  typedef enum logic {IDLE, WAIT} state_e;
  localparam int REG_ADDR_W  = 3;
  localparam int PC_W        = 13;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_ADDR_W  = 13;
  localparam int DEF_TIMEOUT = 16;
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts elapsed request cycles (issue cycle included) and flags the last allowed one.
module mem_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic clear,
  input  logic inc,
  output logic expire
);
  localparam int CW = $clog2(TIMEOUT) + 1;
  logic [CW-1:0] cnt_q, cnt_d;
  // start loads 1 because the issue cycle has already been spent requesting
  always_comb cnt_d = start ? CW'(1) : clear ? '0 : inc ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign expire = cnt_q == CW'(TIMEOUT - 1);
endmodule

// File: rtl/mem_access.sv
// mem_access: memory pipeline stage doing loads/stores over a req/ack bus and registering results for write-back.
// Optional MEM_TIMEOUT_EN aborts a request after TIMEOUT cycles without ack and pulses mem_err.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_in,
  input  logic [PC_W-1:0]       PC,
  input  logic [DATA_W-1:0]     ALURes,
  input  logic [DATA_W-1:0]     StoreData,
  input  logic [REG_ADDR_W-1:0] WriteRegIn,
  input  logic                  write_en,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  output logic                  stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_ack,
  output logic                  valid_out,
  output logic [PC_W-1:0]       PCOut,
  output logic [DATA_W-1:0]     ALUResOut,
  output logic [DATA_W-1:0]     MemReadDataOut,
  output logic [REG_ADDR_W-1:0] WriteRegOut,
  output logic                  write_en_out,
  output logic                  MemReadOut,
  output logic                  mem_err
);
  state_e                  state_q, state_d;
  logic                    idle, waiting, mem_op, complete, abort, issue_wait;
  logic                    valid_q, we_q, mr_q, err_q;
  logic [PC_W-1:0]         pc_q;
  logic [DATA_W-1:0]       alu_q, rdata_q;
  logic [REG_ADDR_W-1:0]   wr_q;
  assign idle       = state_q == IDLE;
  assign waiting    = state_q == WAIT;
  assign mem_op     = valid_in & (MemRead | MemWrite);
  assign issue_wait = idle & mem_op & ~mem_ack;
  // rst_n gates the request so it drops immediately, even mid-transaction
  assign mem_req    = rst_n & ((idle & mem_op) | waiting);
  assign mem_we     = MemWrite & ~MemRead;
  assign mem_addr   = ALURes[ADDR_W-1:0];
  assign mem_wdata  = StoreData;
  assign complete   = (idle & valid_in & (~mem_op | mem_ack)) | (waiting & mem_ack);
  assign stall      = mem_req & ~mem_ack & ~abort;
`ifdef MEM_TIMEOUT_EN
  logic expire;
  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (issue_wait),
    .clear  (complete | abort),
    .inc    (waiting & ~mem_ack),
    .expire (expire)
  );
  assign abort = waiting & ~mem_ack & expire;
`else
  assign abort = 1'b0;
`endif
  always_comb
    state_d = issue_wait ? WAIT : (waiting & (mem_ack | abort)) ? IDLE : state_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  // Anything that is not a completion or abort loads a bubble; payload holds
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid_q <= 1'b0;
      we_q    <= 1'b0;
      mr_q    <= 1'b0;
      err_q   <= 1'b0;
      pc_q    <= '0;
      alu_q   <= '0;
      rdata_q <= '0;
      wr_q    <= '0;
    end else begin
      valid_q <= complete | abort;
      we_q    <= complete & write_en;
      err_q   <= abort;
      if (complete | abort) begin
        pc_q    <= PC;
        alu_q   <= ALURes;
        wr_q    <= WriteRegIn;
        mr_q    <= MemRead;
        rdata_q <= (complete & MemRead) ? mem_rdata : '0;
      end
    end
  assign valid_out      = valid_q;
  assign PCOut          = pc_q;
  assign ALUResOut      = alu_q;
  assign MemReadDataOut = rdata_q;
  assign WriteRegOut    = wr_q;
  assign write_en_out   = we_q & valid_q;
  assign MemReadOut     = mr_q;
  assign mem_err        = err_q;
endmodule
